morph_window_gen: RTL

MORPH_WINDOW_GEN -- requirements
Module: morph_window_gen

---
 rtl/morph_window_gen_if.sv | 24 ++
 rtl/morph_window_gen.sv | 94 +++++++++
 2 files changed

// File: rtl/morph_window_gen_if.sv
// Pixel-in / vertical-window-out bundle for morph_window_gen.
interface morph_window_gen_if #(
  parameter int DATA_W = 10
);
  logic              iDVAL;
  logic              iSOF;
  logic [DATA_W-1:0] iDATA;
  logic              oDVAL;
  logic [DATA_W-1:0] oTAP0;
  logic [DATA_W-1:0] oTAP1;
  logic [DATA_W-1:0] oTAP2;
  logic [9:0]        oCOL;
  logic              oEOL;

  modport master (
    output iDVAL, iSOF, iDATA,
    input  oDVAL, oTAP0, oTAP1, oTAP2, oCOL, oEOL
  );

  modport slave (
    input  iDVAL, iSOF, iDATA,
    output oDVAL, oTAP0, oTAP1, oTAP2, oCOL, oEOL
  );
endinterface

// File: rtl/morph_window_gen.sv
// 3-row vertical window generator: two line memories deliver the pixels
// directly above the current one, gated until two full lines have been seen.
module morph_window_gen #(
  parameter int DATA_W = 10,
  parameter int LINE_W = 640
) (
  input  logic          CLK,
  input  logic          RST_N,
  morph_window_gen_if.slave bus
);
  localparam int         AW   = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [9:0] LAST = 10'(LINE_W - 1);

  typedef enum logic [1:0] {IDLE, FILL0, FILL1, RUN} state_t;

  state_t st, st_nx;

  logic [DATA_W-1:0] la [LINE_W];
  logic [DATA_W-1:0] lb [LINE_W];

  logic [9:0]        col, col_nx, wa;
  logic [AW-1:0]     widx;
  logic              sof, acc, wrap, run_acc;

  logic              dval_q, eol_q;
  logic [DATA_W-1:0] tap0_q, tap1_q, tap2_q;
  logic [9:0]        ocol_q;

  // A start-of-frame pixel always lands at column 0, whatever col holds.
  always_comb begin
    sof     = bus.iDVAL & bus.iSOF;
    acc     = bus.iDVAL & (bus.iSOF | (st != IDLE));
    wa      = sof ? 10'd0 : col;
    widx    = wa[AW-1:0];
    wrap    = acc & (wa == LAST);
    run_acc = acc & ~sof & (st == RUN);
    col_nx  = col;
    if (acc) col_nx = wrap ? 10'd0 : wa + 10'd1;
  end

  always_comb begin
    st_nx = st;
    if (sof) st_nx = FILL0;
    else if (wrap) begin
      case (st)
        FILL0:   st_nx = FILL1;
        FILL1:   st_nx = RUN;
        default: st_nx = st;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) st <= IDLE;
    else        st <= st_nx;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      col    <= '0;
      dval_q <= 1'b0;
      eol_q  <= 1'b0;
      tap0_q <= '0;
      tap1_q <= '0;
      tap2_q <= '0;
      ocol_q <= '0;
    end else begin
      col    <= col_nx;
      dval_q <= run_acc;
      eol_q  <= run_acc & (wa == LAST);
      if (acc) begin
        tap0_q <= bus.iDATA;
        tap1_q <= la[widx];
        tap2_q <= lb[widx];
        ocol_q <= wa;
      end
    end
  end

  // Line memories are never cleared; FILL gating keeps stale rows off oDVAL.
  always_ff @(posedge CLK) begin
    if (acc) begin
      lb[widx] <= la[widx];
      la[widx] <= bus.iDATA;
    end
  end

  assign bus.oDVAL = dval_q;
  assign bus.oEOL  = eol_q;
  assign bus.oTAP0 = tap0_q;
  assign bus.oTAP1 = tap1_q;
  assign bus.oTAP2 = tap2_q;
  assign bus.oCOL  = ocol_q;
endmodule
